uart_float_assembler: RTL and testbench

- Sits directly downstream of the UART receiver in the floating-point UART interface.
- Collects four received bytes into one 32-bit IEEE-754 single-precision word.
- Presents the word to the floating-point datapath with a valid/ready handshake.
- Discards stale partial words after an inter-byte timeout and flags bytes lost while a word is held.

---
 rtl/uart_float_assembler.sv | 185 ++++++++++++++++++
 tb/tb_uart_float_assembler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_float_assembler.sv
// Packs four UART bytes into one IEEE-754 single word with a valid/ready
// handshake, an inter-byte timeout and a sticky overrun flag.
//
// Ports:
//   CLK, reset (sync, active-low), clr (sync soft clear)
//   rx_data/rx_done_tick : byte strobe from the UART receiver
//   word_ready           : downstream accepts word_out
//   word_out/word_valid  : assembled word and its valid flag
//   byte_cnt             : bytes gathered for the current word (0..4)
//   overrun              : sticky, byte dropped while a word was held
//   timeout_err          : one-cycle pulse, partial word discarded
// Optional macro FLOAT_CLASSIFY_EN adds is_zero/is_inf/is_nan/is_denorm.
module uart_float_assembler #(
  parameter int LITTLE_ENDIAN  = 1,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int TO_W           = 21
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done_tick,
  input  logic        clr,
  input  logic        word_ready,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic [2:0]  byte_cnt,
  output logic        overrun,
`ifdef FLOAT_CLASSIFY_EN
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_denorm,
`endif
  output logic        timeout_err
);

  typedef enum logic {COLLECT, HOLD} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       word_q, word_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              terr_q, terr_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              done;
`ifdef FLOAT_CLASSIFY_EN
  logic [3:0]        cls_q, cls_d;
`endif

  // Drop a byte into its lane; slot 0 is the first byte of a word.
  function automatic logic [31:0] put(
    input logic [31:0] w,
    input logic [1:0]  slot,
    input logic [7:0]  b
  );
    logic [31:0] r;
    logic [4:0]  sh;
    r = w;
    if (LITTLE_ENDIAN != 0) sh = {slot, 3'b000};
    else                    sh = {~slot, 3'b000};
    r[sh +: 8] = b;
    return r;
  endfunction

  // State register
  always_ff @(posedge CLK) begin
    if (!reset) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        COLLECT: if (rx_done_tick && cnt_q == 3'd3) state_d = HOLD;
        HOLD:    if (word_ready) state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  assign done = !clr && state_q == COLLECT
             && rx_done_tick && cnt_q == 3'd3;

  // Datapath next-state
  always_comb begin
    buf_d  = buf_q;
    word_d = word_q;
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
    terr_d = 1'b0;
    tcnt_d = tcnt_q;
    if (clr) begin
      cnt_d  = 3'd0;
      ovr_d  = 1'b0;
      tcnt_d = '0;
    end else if (state_q == COLLECT) begin
      if (rx_done_tick) begin
        buf_d  = put(buf_q, cnt_q[1:0], rx_data);
        cnt_d  = cnt_q + 3'd1;
        tcnt_d = '0;
        if (cnt_q == 3'd3) word_d = buf_d;
      end else if (cnt_q == 3'd0) begin
        tcnt_d = '0;
      end else if (tcnt_q == TO_LAST) begin
        cnt_d  = 3'd0;
        tcnt_d = '0;
        terr_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end else begin
      tcnt_d = '0;
      if (word_ready) begin
        cnt_d = 3'd0;
        // A byte on the handshake cycle starts the next word.
        if (rx_done_tick) begin
          buf_d = put(buf_q, 2'd0, rx_data);
          cnt_d = 3'd1;
        end
      end else if (rx_done_tick) begin
        ovr_d = 1'b1;
      end
    end
  end

`ifdef FLOAT_CLASSIFY_EN
  // Order: {zero, inf, nan, denorm}
  always_comb begin
    cls_d = cls_q;
    if (done) begin
      cls_d[3] = word_d[30:23] == 8'h00 && word_d[22:0] == '0;
      cls_d[2] = word_d[30:23] == 8'hFF && word_d[22:0] == '0;
      cls_d[1] = word_d[30:23] == 8'hFF && word_d[22:0] != '0;
      cls_d[0] = word_d[30:23] == 8'h00 && word_d[22:0] != '0;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!reset) begin
      buf_q  <= '0;
      word_q <= '0;
      cnt_q  <= 3'd0;
      ovr_q  <= 1'b0;
      terr_q <= 1'b0;
      tcnt_q <= '0;
`ifdef FLOAT_CLASSIFY_EN
      cls_q  <= '0;
`endif
    end else begin
      buf_q  <= buf_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
      terr_q <= terr_d;
      tcnt_q <= tcnt_d;
`ifdef FLOAT_CLASSIFY_EN
      cls_q  <= cls_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    word_out    = word_q;
    word_valid  = state_q == HOLD;
    byte_cnt    = cnt_q;
    overrun     = ovr_q;
    timeout_err = terr_q;
`ifdef FLOAT_CLASSIFY_EN
    is_zero     = cls_q[3];
    is_inf      = cls_q[2];
    is_nan      = cls_q[1];
    is_denorm   = cls_q[0];
`endif
  end

endmodule

// File: tb/tb_uart_float_assembler.sv
// Bench for uart_float_assembler: little- and big-endian instances
// share stimulus and are checked each cycle against a byte-level model.
module tb_uart_float_assembler;

  localparam int TO = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       clr = 1'b0;
  logic       word_ready = 1'b0;

  logic [31:0] wo_le, wo_be;
  logic        wv_le, wv_be;
  logic [2:0]  bc_le, bc_be;
  logic        ov_le, ov_be;
  logic        te_le, te_be;
`ifdef FLOAT_CLASSIFY_EN
  logic [3:0]  cl_le, cl_be;
`endif

  uart_float_assembler #(
    .LITTLE_ENDIAN(1), .TIMEOUT_CYCLES(TO), .TO_W(4)
  ) dut_le (
    .CLK(CLK), .reset(reset), .rx_data(rx_data),
    .rx_done_tick(rx_done_tick), .clr(clr),
    .word_ready(word_ready), .word_out(wo_le),
    .word_valid(wv_le), .byte_cnt(bc_le),
    .overrun(ov_le),
`ifdef FLOAT_CLASSIFY_EN
    .is_zero(cl_le[3]), .is_inf(cl_le[2]),
    .is_nan(cl_le[1]), .is_denorm(cl_le[0]),
`endif
    .timeout_err(te_le)
  );

  uart_float_assembler #(
    .LITTLE_ENDIAN(0), .TIMEOUT_CYCLES(TO), .TO_W(4)
  ) dut_be (
    .CLK(CLK), .reset(reset), .rx_data(rx_data),
    .rx_done_tick(rx_done_tick), .clr(clr),
    .word_ready(word_ready), .word_out(wo_be),
    .word_valid(wv_be), .byte_cnt(bc_be),
    .overrun(ov_be),
`ifdef FLOAT_CLASSIFY_EN
    .is_zero(cl_be[3]), .is_inf(cl_be[2]),
    .is_nan(cl_be[1]), .is_denorm(cl_be[0]),
`endif
    .timeout_err(te_be)
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  bit armed = 0;

  // Model: index 0 little-endian, 1 big-endian
  logic [7:0]  mb [2][4];
  int          mn [2];
  bit          mv [2];
  logic [31:0] mw [2];
  bit          mo [2];
  bit          mt [2];
  int          midle [2];
  logic [3:0]  mc [2];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] assemble(input int k);
    logic [31:0] w = 0;
    for (int i = 0; i < 4; i++) begin
      if (k == 0) w = w | ({24'b0, mb[k][i]} << (8 * i));
      else        w = w | ({24'b0, mb[k][i]} << (8 * (3 - i)));
    end
    return w;
  endfunction

  function automatic logic [3:0] classify(input logic [31:0] w);
    int e = int'(w[30:23]);
    bit m = w[22:0] != 0;
    return {e == 0 && !m, e == 255 && !m, e == 255 && m, e == 0 && m};
  endfunction

  task automatic model_step(input int k);
    if (!reset) begin
      mn[k] = 0; mv[k] = 0; mw[k] = 0; mo[k] = 0;
      mt[k] = 0; midle[k] = 0; mc[k] = 0;
      return;
    end
    mt[k] = 0;
    if (clr) begin
      mn[k] = 0; mv[k] = 0; mo[k] = 0; midle[k] = 0;
    end else if (mv[k]) begin
      if (word_ready) begin
        mv[k] = 0; mn[k] = 0; midle[k] = 0;
        if (rx_done_tick) begin
          mb[k][0] = rx_data;
          mn[k] = 1;
        end
      end else if (rx_done_tick) begin
        mo[k] = 1;
      end
    end else if (rx_done_tick) begin
      mb[k][mn[k]] = rx_data;
      mn[k]++;
      midle[k] = 0;
      if (mn[k] == 4) begin
        mw[k] = assemble(k);
        mc[k] = classify(mw[k]);
        mv[k] = 1;
      end
    end else if (mn[k] > 0) begin
      if (midle[k] == TO - 1) begin
        mn[k] = 0; midle[k] = 0; mt[k] = 1;
      end else begin
        midle[k]++;
      end
    end
  endtask

  always @(posedge CLK) begin
    model_step(0);
    model_step(1);
    armed = 1;
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("le.word_out", wo_le, mw[0]);
      chk("le.word_valid", 32'(wv_le), 32'(mv[0]));
      chk("le.byte_cnt", 32'(bc_le), mv[0] ? 4 : mn[0]);
      chk("le.overrun", 32'(ov_le), 32'(mo[0]));
      chk("le.timeout_err", 32'(te_le), 32'(mt[0]));
      chk("be.word_out", wo_be, mw[1]);
      chk("be.word_valid", 32'(wv_be), 32'(mv[1]));
      chk("be.byte_cnt", 32'(bc_be), mv[1] ? 4 : mn[1]);
      chk("be.overrun", 32'(ov_be), 32'(mo[1]));
      chk("be.timeout_err", 32'(te_be), 32'(mt[1]));
`ifdef FLOAT_CLASSIFY_EN
      chk("le.class", 32'(cl_le), 32'(mc[0]));
      chk("be.class", 32'(cl_be), 32'(mc[1]));
`endif
      if (te_le) pulses++;
    end
  end

  // Sets inputs for the next rising edge; on return, outputs
  // reflect the previous edge.
  task automatic step(input logic t, input logic [7:0] d,
                      input logic rdy, input logic c);
    @(negedge CLK);
    rx_done_tick = t;
    rx_data      = d;
    word_ready   = rdy;
    clr          = c;
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0);
  endtask

  initial begin
    int hit;
    int npulse;
    repeat (2) idle();
    reset = 1'b1;
    idle();
    chk("reset.word_out", wo_le, 32'h0);
    chk("reset.valid", 32'(wv_le), 0);
    chk("reset.cnt", 32'(bc_le), 0);

    // 1.0f little-endian
    step(1, 8'h00, 0, 0);
    step(1, 8'h00, 0, 0);
    step(1, 8'h80, 0, 0);
    step(1, 8'h3F, 0, 0);
    chk("t1.cnt3", 32'(bc_le), 3);
    chk("t1.notyet", 32'(wv_le), 0);
    idle();
    chk("t1.valid", 32'(wv_le), 1);
    chk("t1.word", wo_le, 32'h3F800000);
    chk("t1.cnt4", 32'(bc_le), 4);
    chk("t1.be_word", wo_be, 32'h0000803F);
    step(0, 8'h00, 1, 0);
    idle();
    chk("t1.hs_valid", 32'(wv_le), 0);
    chk("t1.hs_cnt", 32'(bc_le), 0);

    // -pi big-endian
    step(1, 8'hC0, 0, 0);
    step(1, 8'h49, 0, 0);
    step(1, 8'h0F, 0, 0);
    step(1, 8'hDB, 0, 0);
    idle();
    chk("t2.be_word", wo_be, 32'hC0490FDB);
    chk("t2.le_word", wo_le, 32'hDB0F49C0);
    step(0, 8'h00, 1, 0);
    idle();
`ifdef FLOAT_CLASSIFY_EN
    step(1, 8'h00, 0, 0);
    step(1, 8'h00, 0, 0);
    step(1, 8'hC0, 0, 0);
    step(1, 8'h7F, 0, 0);
    idle();
    chk("t2.le_nan", wo_le, 32'h7FC00000);
    chk("t2.le_class", 32'(cl_le), 32'b0010);
    chk("t2.be_class", 32'(cl_be), 32'b0001);
    step(0, 8'h00, 1, 0);
    idle();
`endif

    // Timeout after two bytes
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    hit = 0;
    npulse = 0;
    for (int k = 1; k <= 12; k++) begin
      idle();
      if (te_le) begin
        hit = k;
        npulse++;
      end
    end
    chk("t3.pulse_at", hit, 9);
    chk("t3.pulse_n", npulse, 1);
    chk("t3.cnt", 32'(bc_le), 0);
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    step(1, 8'h04, 0, 0);
    idle();
    chk("t3.le_word", wo_le, 32'h04030201);
    chk("t3.be_word", wo_be, 32'h01020304);

    // Overrun while held, then tick on handshake
    step(1, 8'hAA, 0, 0);
    idle();
    chk("t4.ovr", 32'(ov_le), 1);
    chk("t4.word", wo_le, 32'h04030201);
    chk("t4.held", 32'(wv_le), 1);
    step(1, 8'h55, 1, 0);
    idle();
    chk("t4.hs_valid", 32'(wv_le), 0);
    chk("t4.hs_cnt", 32'(bc_le), 1);
    chk("t4.ovr_stay", 32'(ov_le), 1);
    step(0, 8'h00, 0, 1);
    idle();
    chk("t4.clr_ovr", 32'(ov_le), 0);
    chk("t4.clr_cnt", 32'(bc_le), 0);

    // Reset mid-word
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    idle();
    reset = 1'b0;
    idle();
    reset = 1'b1;
    chk("t5.rst_cnt", 32'(bc_le), 0);
    chk("t5.rst_word", wo_le, 32'h0);

    // clr with the 4th tick
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    step(1, 8'h04, 0, 1);
    idle();
    chk("t5.clr_valid", 32'(wv_le), 0);
    chk("t5.clr_cnt", 32'(bc_le), 0);
    repeat (12) idle();
    chk("t5.total_pulses", pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
